// File: rtl/aes_dec_pkg.sv
// Shared widths, round count and FSM encoding for the AES-128 decrypt sequencer.
package aes_dec_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int KEY_IDX_W   = 4;
  localparam int NR_AES128   = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARK0  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } dec_state_e;

  typedef logic [AES_BLOCK_W-1:0] aes_blk_t;

  // AddRoundKey is a plain 128-bit XOR; kept as a function so both uses read alike.
  function automatic aes_blk_t add_round_key(input aes_blk_t s, input aes_blk_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_dec_round_timer.sv
// Loadable down-counter; done marks the final cycle of a datapath round wait.
module aes_dec_round_timer #(
  parameter int ROUND_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Load ROUND_LAT-1 on issue, then count down to zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(ROUND_LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/aes_decrypt_round_ctrl.sv
// Iterative AES-128 decryption sequencer driving one shared inverse-round datapath.
module aes_decrypt_round_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NR        = NR_AES128,
  parameter int ROUND_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic [KEY_IDX_W-1:0]   key_idx,
  input  logic [AES_BLOCK_W-1:0] key_in,
  output logic                   rnd_start,
  output logic                   rnd_last,
  output logic [AES_BLOCK_W-1:0] rnd_data,
  output logic [AES_BLOCK_W-1:0] rnd_key,
  input  logic [AES_BLOCK_W-1:0] rnd_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  dec_state_e           state, state_nxt;
  aes_blk_t             cap_q;
  aes_blk_t             st_q;
  aes_blk_t             out_q;
  logic [KEY_IDX_W-1:0] rnd_q;
  logic                 tmr_done;
  logic                 in_fire;
  logic                 out_fire;
  logic                 last_wait;
  logic                 in_round;

  assign in_fire   = (state == IDLE) && in_valid && in_ready;
  assign out_fire  = (state == DONE) && out_ready;
  assign last_wait = (state == WAIT) && tmr_done;
  assign in_round  = (state == ISSUE) || (state == WAIT);

  aes_dec_round_timer #(
    .ROUND_LAT (ROUND_LAT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (state == ISSUE),
    .done  (tmr_done)
  );

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_fire) state_nxt = ARK0;
        ARK0:    state_nxt = ISSUE;
        ISSUE:   state_nxt = WAIT;
        WAIT:    if (tmr_done) state_nxt = (rnd_q == '0) ? DONE : ISSUE;
        DONE:    if (out_fire) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Block capture, running state, round counter and plaintext holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      st_q  <= '0;
      rnd_q <= KEY_IDX_W'(NR - 1);
      out_q <= '0;
    end else if (!flush) begin
      if (in_fire) cap_q <= in_data;
      if (state == ARK0) begin
        st_q  <= add_round_key(cap_q, key_in);
        rnd_q <= KEY_IDX_W'(NR - 1);
      end
      if (last_wait) begin
        if (rnd_q != '0) begin
          st_q  <= rnd_result;
          rnd_q <= rnd_q - KEY_IDX_W'(1);
        end else begin
          // Final AddRoundKey: key_idx is 0 in this cycle.
          out_q <= add_round_key(rnd_result, key_in);
        end
      end
    end
  end

  // in_ready is gated by rst_n so it is low for the whole reset window.
  assign in_ready  = rst_n && (state == IDLE);
  assign key_idx   = (state == ARK0) ? KEY_IDX_W'(NR) :
                     in_round        ? rnd_q          : '0;
  assign rnd_start = (state == ISSUE);
  assign rnd_last  = in_round && (rnd_q == '0);
  assign rnd_data  = st_q;
  assign rnd_key   = key_in;
  assign out_valid = (state == DONE);
  assign out_data  = out_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_decrypt_round_ctrl.sv
// Directed bench for aes_decrypt_round_ctrl with key-store and inverse-round models.
`timescale 1ns/1ps
module tb_aes_decrypt_round_ctrl;

  localparam int NR       = 10;
  localparam int LAT      = 2;
  localparam int LAT_MAIN = 1 + NR * (1 + LAT);
  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] GARB  = 128'hdeadbeef_0badf00d_deadbeef_0badf00d;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, rnd_start, rnd_last, out_valid, busy;
  logic [3:0]   key_idx;
  logic [127:0] key_in, rnd_data, rnd_key, rnd_result, out_data;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [NR+1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_round_ctrl #(.NR(NR), .ROUND_LAT(LAT)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .key_idx    (key_idx),
    .key_in     (key_in),
    .rnd_start  (rnd_start),
    .rnd_last   (rnd_last),
    .rnd_data   (rnd_data),
    .rnd_key    (rnd_key),
    .rnd_result (rnd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic build_keys(input logic [127:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // InvShiftRows, InvSubBytes, then (full round only) AddRoundKey and InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rkey,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] t;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r + 4*((c + r) % 4)] = isbox[a[r + 4*c]];
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = b[i];
    if (last) return t;
    t = t ^ rkey;
    for (int i = 0; i < 16; i++) a[i] = t[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      b[4*c]   = gm(a[4*c],8'h0e) ^ gm(a[4*c+1],8'h0b) ^ gm(a[4*c+2],8'h0d) ^ gm(a[4*c+3],8'h09);
      b[4*c+1] = gm(a[4*c],8'h09) ^ gm(a[4*c+1],8'h0e) ^ gm(a[4*c+2],8'h0b) ^ gm(a[4*c+3],8'h0d);
      b[4*c+2] = gm(a[4*c],8'h0d) ^ gm(a[4*c+1],8'h09) ^ gm(a[4*c+2],8'h0e) ^ gm(a[4*c+3],8'h0b);
      b[4*c+3] = gm(a[4*c],8'h0b) ^ gm(a[4*c+1],8'h0d) ^ gm(a[4*c+2],8'h09) ^ gm(a[4*c+3],8'h0e);
    end
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = b[i];
    return t;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s ^ rk[0];
  endfunction

  // ---------------- key store and datapath model (main DUT) ----------------
  assign key_in = (key_idx <= 4'(NR)) ? rk[key_idx] : '0;

  // Result is only meaningful exactly LAT cycles after rnd_start; garbage otherwise.
  logic [127:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= rnd_start ? inv_round(rnd_data, rnd_key, rnd_last) : GARB;
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign rnd_result = dp_pipe[LAT-1];

  // ---------------- extra builds: ROUND_LAT = 1 and 4 ----------------
  logic x_go = 1'b0;
  for (genvar g = 0; g < 2; g++) begin : g_x
    localparam int L = (g == 0) ? 1 : 4;
    logic         ir, ov, rs, rl, bz;
    logic [3:0]   ki;
    logic [127:0] kin, rd, rkey, rres, od;
    logic [127:0] pipe [L];

    aes_decrypt_round_ctrl #(.NR(NR), .ROUND_LAT(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (1'b0),
      .in_valid   (x_go),
      .in_ready   (ir),
      .in_data    (C1_CT),
      .key_idx    (ki),
      .key_in     (kin),
      .rnd_start  (rs),
      .rnd_last   (rl),
      .rnd_data   (rd),
      .rnd_key    (rkey),
      .rnd_result (rres),
      .out_valid  (ov),
      .out_ready  (1'b1),
      .out_data   (od),
      .busy       (bz)
    );

    assign kin = (ki <= 4'(NR)) ? rk[ki] : '0;
    always @(posedge clk) begin
      pipe[0] <= rs ? inv_round(rd, rkey, rl) : GARB;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rres = pipe[L-1];
  end

  // ---------------- key_idx / rnd_last trace monitor ----------------
  logic trace_en = 1'b0;
  int   tr_q[$];
  int   tr_last_bad = 0;
  int   tr_rs = 0;
  always @(negedge clk) begin
    if (trace_en && busy && !out_valid) begin
      tr_q.push_back(int'(key_idx));
      if (rnd_last != (key_idx == 4'd0)) tr_last_bad++;
      if (rnd_start) tr_rs++;
    end
  end

  // ---------------- checking and sequencing helpers ----------------
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle index of the accepting edge.
  task automatic accept(output int t);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("in_ready_seen", 128'(in_ready), 128'(1));
    tick();
    t = cyc;
  endtask

  task automatic send(input logic [127:0] ct, output int t);
    in_data  = ct;
    in_valid = 1'b1;
    accept(t);
    in_valid = 1'b0;
  endtask

  // Returns the cycle index of the edge that raised out_valid.
  task automatic wait_out(output int t);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("out_valid_seen", 128'(out_valid), 128'(1));
    t = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, t, a2, t2, bad, n, t0, t1;
    logic [127:0] d0, d1, exp_z, exp_r;

    build_tables();
    build_keys(KEY);
    exp_z = ref_dec('0);
    exp_r = ref_dec(128'hfedcba9876543210_0123456789abcdef);

    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_ctrl", 128'({busy, out_valid, rnd_start, rnd_last, key_idx}), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_rnd_data", rnd_data, '0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    chk("ref_model_c1", ref_dec(C1_CT), C1_PT);

    // FIPS-197 C.1 with trace
    out_ready = 1'b1;
    tr_q.delete();
    trace_en = 1'b1;
    send(C1_CT, a);
    wait_out(t);
    trace_en = 1'b0;
    chk("c1_latency", 128'(t - a), 128'(LAT_MAIN));
    chk("c1_plaintext", out_data, C1_PT);
    tick();
    chk("trace_len", 128'(tr_q.size()), 128'(LAT_MAIN));
    bad = 0;
    for (int i = 0; i < tr_q.size(); i++)
      if (tr_q[i] != ((i == 0) ? NR : NR - 1 - (i - 1) / (LAT + 1))) bad++;
    chk("trace_key_idx", 128'(bad), 128'(0));
    chk("trace_rnd_last", 128'(tr_last_bad), 128'(0));
    chk("trace_rnd_start_cnt", 128'(tr_rs), 128'(NR));

    // Backpressure
    out_ready = 1'b0;
    send(C1_CT, a);
    wait_out(t);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!out_valid || out_data !== C1_PT || in_ready || !busy) bad++;
    end
    chk("bp_stable", 128'(bad), 128'(0));
    out_ready = 1'b1;
    chk("bp_in_ready_held", 128'(in_ready), 128'(0));
    tick();
    chk("bp_release", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // Back-to-back with in_valid held high
    in_data  = C1_CT;
    in_valid = 1'b1;
    accept(a);
    in_data  = '0;
    wait_out(t);
    chk("b2b_pt1", out_data, C1_PT);
    accept(a2);
    in_valid = 1'b0;
    chk("b2b_gap", 128'(a2 - t), 128'(2));
    chk("b2b_period", 128'(a2 - a), 128'(LAT_MAIN + 2));
    wait_out(t2);
    chk("b2b_pt2", out_data, exp_z);
    tick();

    // Flush during WAIT of round 5
    send(C1_CT, a);
    n = 0;
    while (!(busy && key_idx == 4'd5 && !rnd_start) && n < 200) begin tick(); n++; end
    chk("flush_reach_r5", 128'(key_idx), 128'(5));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle", 128'({busy, out_valid, in_ready}), 128'(3'b001));
    bad = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (out_valid || busy) bad++;
    end
    chk("flush_quiet", 128'(bad), 128'(0));
    send(128'hfedcba9876543210_0123456789abcdef, a);
    wait_out(t);
    chk("flush_recover_lat", 128'(t - a), 128'(LAT_MAIN));
    chk("flush_recover_pt", out_data, exp_r);
    tick();

    // Async reset during ISSUE of round 3
    send(C1_CT, a);
    n = 0;
    while (!(rnd_start && key_idx == 4'd3) && n < 200) begin tick(); n++; end
    chk("arst_reach_r3", 128'({rnd_start, key_idx}), 128'({1'b1, 4'd3}));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 128'({busy, out_valid, rnd_start, rnd_last, in_ready, key_idx}), 128'(0));
    chk("arst_out_data", out_data, '0);
    chk("arst_rnd_data", rnd_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(C1_CT, a);
    wait_out(t);
    chk("arst_recover_lat", 128'(t - a), 128'(LAT_MAIN));
    chk("arst_recover_pt", out_data, C1_PT);
    tick();

    // ROUND_LAT = 1 and 4 builds, started together
    chk("lat_x_ready", 128'({g_x[0].ir, g_x[1].ir}), 128'(2'b11));
    x_go = 1'b1;
    tick();
    x_go = 1'b0;
    a  = cyc;
    t0 = -1; t1 = -1;
    d0 = '0; d1 = '0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (g_x[0].ov && t0 < 0) begin t0 = cyc; d0 = g_x[0].od; end
      if (g_x[1].ov && t1 < 0) begin t1 = cyc; d1 = g_x[1].od; end
    end
    chk("lat1_latency", 128'(t0 - a), 128'(1 + NR * 2));
    chk("lat1_plaintext", d0, C1_PT);
    chk("lat4_latency", 128'(t1 - a), 128'(1 + NR * 5));
    chk("lat4_plaintext", d1, C1_PT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_round_ctrl.md
Name: aes_decrypt_round_ctrl

Overview:
- Iterative AES-128 decryption sequencer. Accepts one ciphertext block per transaction and drives a single shared round datapath NR times.
- Datapath = full inverse round plus the last-round variant (InvShiftRows/InvSubBytes only, no AddRoundKey).
- Performs the initial and final AddRoundKey itself, fetches round keys by index from the key store, and returns the plaintext over a valid/ready handshake.

Parameters:
- NR, 10, number of decryption rounds (AES-128).
- ROUND_LAT, 2, cycles from rnd_start to a valid rnd_result; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns to IDLE
- in_valid  in  1  ciphertext offered
- in_ready  out  1  controller can accept
- in_data  in  128  ciphertext block
- key_idx  out  4  round-key index to key store
- key_in  in  128  round key for key_idx; combinational, same cycle
- rnd_start  out  1  one-cycle pulse launching a datapath round
- rnd_last  out  1  selects the last-round path (no InvMixColumns, no AddRoundKey)
- rnd_data  out  128  datapath input state
- rnd_key  out  128  round key forwarded to datapath (= key_in)
- rnd_result  in  128  datapath output
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts
- out_data  out  128  plaintext block
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, round counter=NR-1, wait counter=0, state register=0, out_data=0, out_valid=0, rnd_start=0, rnd_last=0, key_idx=0, in_ready=0 while in reset, 1 after release.
- States: IDLE, ARK0, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - in_valid & in_ready -> ARK0, capture in_data.
- ARK0 (1 cycle):
  - key_idx=NR.
  - state reg <= captured ^ key_in.
  - round counter r=NR-1.
  - -> ISSUE.
- ISSUE (1 cycle):
  - rnd_start=1; rnd_data=state reg; key_idx=r; rnd_last=(r==0).
  - Wait counter loads ROUND_LAT-1.
  - -> WAIT.
- WAIT (ROUND_LAT cycles):
  - rnd_data, key_idx and rnd_last held stable; rnd_start=0.
  - On the last WAIT cycle:
    - r>0: state reg <= rnd_result, r <= r-1, -> ISSUE.
    - r==0: out_data <= rnd_result ^ key_in (key_idx=0), -> DONE.
- DONE:
  - out_valid=1; out_data held stable until out_ready.
  - out_valid & out_ready -> IDLE. in_ready rises the following cycle (no same-cycle re-accept).
- Latency, acceptance edge to the out_valid-rising edge: 1 + NR*(1+ROUND_LAT) cycles (31 with defaults). Throughput: one block per latency+2 cycles with out_ready tied high.
- key_idx sequence per block: NR, NR-1, ..., 0. Each index is held for 1+ROUND_LAT cycles, except NR, which is held 1 cycle.
- flush:
  - Any state -> IDLE next cycle; out_valid=0; in-flight rnd_result ignored.
  - flush has priority over in_valid and out_ready in the same cycle.
- rst_n mid-operation: immediate return to reset values; datapath outputs ignored thereafter.
- in_valid while busy: ignored (in_ready=0); in_data must be held by the source.
- All XORs are 128-bit bitwise; no width extension.

Decomposition:
- Package aes_dec_pkg holds:
  - AES_BLOCK_W=128
  - KEY_IDX_W=4
  - NR_AES128=10
  - state enum {IDLE, ARK0, ISSUE, WAIT, DONE}
- One sub-module, aes_dec_round_timer: loadable down-counter producing the done flag for the last WAIT cycle, parameterised by ROUND_LAT.

Test Plan:
- FIPS-197 C.1 decryption, with key-store and datapath reference models:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1.
  - Required: out_data=00112233445566778899aabbccddeeff, out_valid rises exactly 31 cycles after acceptance.
  - Required: key_idx trace 10,9,...,0; rnd_last high only during round 0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data/out_valid stable, in_ready=0, busy=1; on release, in_ready=1 one cycle later.
- Back-to-back: two blocks (C.1 vector, then all-zero ciphertext under the same key), in_valid held high -> second acceptance exactly 2 cycles after first out_valid&out_ready, both plaintexts match the model.
- Flush during round 5 WAIT -> IDLE next cycle, no out_valid; next block decrypts correctly.
- rst_n low during ISSUE of round 3 -> all outputs at reset values asynchronously; recovery transaction correct.
- ROUND_LAT=1 and ROUND_LAT=4 builds: C.1 vector correct with latency 21 and 51 respectively.
